// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder and sequential instruction-memory loader.
// Accepts one field bundle per two cycles and writes the packed word at the session's next address.
module instr_encoder #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          full,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t        state, state_nxt;
  logic          accept;
  logic [32:0]   enc;
  logic          last_p0;
  logic [31:0]   word_p0;
  logic [AW-1:0] addr_p0;

  // True when v is the sign extension of its bits below 'sh' (v[31:sh] all equal).
  function automatic logic fits(input logic signed [31:0] v, input int sh);
    logic signed [31:0] t;
    t = v >>> sh;
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  // Returns {error, word}; out-of-range immediates are truncated by the packing itself.
  function automatic logic [32:0] encode(
    input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic signed [31:0] im);
    logic [32:0] r;
    case (f)
      3'd0: r = {1'b0, f7, s2, s1, f3, d, op};
      3'd1: r = {~fits(im, 11), im[11:0], s1, f3, d, op};
      3'd2: r = {~fits(im, 11), im[11:5], s2, s1, f3, im[4:0], op};
      3'd3: r = {~fits(im, 12) | im[0], im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      3'd4: r = {|im[11:0], im[31:12], d, op};
      3'd5: r = {~fits(im, 20) | im[0], im[20], im[10:1], im[11], im[19:12], d, op};
      default: r = {1'b1, NOP};
    endcase
    return r;
  endfunction

  assign enc = encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, $signed(imm));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        if (!start && in_valid) begin
          accept    = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (last_p0 || (count + (AW+1)'(1)) == DEPTH_C) state_nxt = DONE;
        else                                            state_nxt = LOAD;
      end
      DONE:  if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: accepted bundle captured, written during WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      err     <= 1'b0;
      last_p0 <= 1'b0;
      word_p0 <= '0;
      addr_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (start && state != WRITE) begin
        count <= '0;
        err   <= 1'b0;
      end
      if (accept) begin
        word_p0 <= enc[31:0];
        addr_p0 <= count[AW-1:0];
        last_p0 <= in_last;
        if (enc[32]) err <= 1'b1;
      end
      if (state == WRITE) count <= count + (AW+1)'(1);
    end
  end

  assign in_ready   = (state == LOAD);
  assign imem_we    = (state == WRITE);
  assign imem_addr  = addr_p0;
  assign imem_wdata = word_p0;
  assign done       = (state == DONE);
  assign full       = (count == DEPTH_C);

endmodule
